// File: rtl/armleg_pipe_pkg.sv
// Shared pipeline definitions: zero-register index and scoreboard entry flags.
package armleg_pipe_pkg;

    localparam int unsigned ZERO_REG_DEF = 31;

    typedef struct packed {
        logic valid;
        logic regwrite;
        logic memread;
    } ex_flags_t;

    localparam ex_flags_t EX_BUBBLE = '{valid: 1'b0, regwrite: 1'b0, memread: 1'b0};

    // A live load whose result is not available until after MEM.
    function automatic logic is_load(input ex_flags_t f);
        return f.valid & f.memread;
    endfunction

endpackage

// File: rtl/fwd_prio_match.sv
// One source operand: compare against every post-EX stage and pick the youngest producer.
module fwd_prio_match
    import armleg_pipe_pkg::*;
#(
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned ZERO_REG = ZERO_REG_DEF,
    parameter int unsigned SELW     = 2
) (
    input  logic [DEPTH-1:0]        st_wr,
    input  logic [DEPTH*REG_AW-1:0] st_rd,
    input  logic [REG_AW-1:0]       src,
    output logic [SELW-1:0]         sel
);

    localparam logic [REG_AW-1:0] ZR = REG_AW'(ZERO_REG);

    logic found;

    // Priority encode: the lowest-numbered (youngest) matching stage wins.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (!found && st_wr[k] && (st_rd[k*REG_AW +: REG_AW] == src) && (src != ZR)) begin
                sel   = SELW'(k + 1);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fwd_scoreboard.sv
// Forwarding/hazard controller: in-flight write scoreboard, per-source forward select,
// load-use stall with bubble insertion, saturating stall counter.
module fwd_scoreboard
    import armleg_pipe_pkg::*;
#(
    parameter int unsigned NUM_SRC  = 2,
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned ZERO_REG = ZERO_REG_DEF,
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned CNT_W    = 16,
    localparam int unsigned SELW    = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      adv,
    input  logic                      flush,
    input  logic                      id_valid,
    input  logic [NUM_SRC*REG_AW-1:0] id_src,
    input  logic                      id_regwrite,
    input  logic                      id_memread,
    input  logic [REG_AW-1:0]         id_rd,
    input  logic [NUM_SRC*REG_AW-1:0] ex_src,
    output logic [NUM_SRC*SELW-1:0]   fwd_sel,
    output logic                      stall,
    output logic [CNT_W-1:0]          stall_count
);

    localparam logic [REG_AW-1:0] ZR = REG_AW'(ZERO_REG);

    typedef struct packed {
        ex_flags_t         f;
        logic [REG_AW-1:0] rd;
    } ex_entry_t;

    // Post-EX stages drop memread: nothing downstream of EX reads it.
    typedef struct packed {
        logic              valid;
        logic              regwrite;
        logic [REG_AW-1:0] rd;
    } st_entry_t;

    ex_entry_t          ex_e_q, ex_e_d;
    st_entry_t          st_q [DEPTH];
    st_entry_t          st_d [DEPTH];
    logic [CNT_W-1:0]   stall_count_q, stall_count_d;
    logic               src_hit;
    logic               stall_w;
    logic [DEPTH-1:0]        st_wr;
    logic [DEPTH*REG_AW-1:0] st_rd;

    // Load-use hazard: ID reads the register a load in EX has not produced yet.
    always_comb begin
        src_hit = 1'b0;
        for (int unsigned j = 0; j < NUM_SRC; j++) begin
            if (id_src[j*REG_AW +: REG_AW] == ex_e_q.rd) src_hit = 1'b1;
        end
        stall_w = id_valid & is_load(ex_e_q.f) & (ex_e_q.rd != ZR) & src_hit & ~flush;
    end

    // Next scoreboard state: shift on adv, bubble EX on stall/flush/empty ID, count stalls.
    always_comb begin
        ex_e_d        = ex_e_q;
        st_d          = st_q;
        stall_count_d = stall_count_q;
        if (adv) begin
            st_d[0] = '{valid: ex_e_q.f.valid, regwrite: ex_e_q.f.regwrite, rd: ex_e_q.rd};
            for (int unsigned k = 1; k < DEPTH; k++) begin
                st_d[k] = st_q[k-1];
            end
            if (stall_w | flush | ~id_valid) begin
                ex_e_d = '{f: EX_BUBBLE, rd: '0};
            end else begin
                ex_e_d = '{f: '{valid: 1'b1, regwrite: id_regwrite, memread: id_memread}, rd: id_rd};
            end
            if (stall_w && (stall_count_q != '1)) begin
                stall_count_d = stall_count_q + CNT_W'(1);
            end
        end
    end

    // State registers with synchronous reset that empties the whole scoreboard.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_e_q <= '{f: EX_BUBBLE, rd: '0};
            for (int unsigned k = 0; k < DEPTH; k++) begin
                st_q[k] <= '0;
            end
            stall_count_q <= '0;
        end else begin
            ex_e_q        <= ex_e_d;
            st_q          <= st_d;
            stall_count_q <= stall_count_d;
        end
    end

    // Flatten stage state for the per-source matchers.
    always_comb begin
        for (int unsigned k = 0; k < DEPTH; k++) begin
            st_wr[k]                    = st_q[k].valid & st_q[k].regwrite;
            st_rd[k*REG_AW +: REG_AW]   = st_q[k].rd;
        end
    end

    for (genvar j = 0; j < NUM_SRC; j++) begin : g_src
        fwd_prio_match #(
            .REG_AW   (REG_AW),
            .DEPTH    (DEPTH),
            .ZERO_REG (ZERO_REG),
            .SELW     (SELW)
        ) u_match (
            .st_wr (st_wr),
            .st_rd (st_rd),
            .src   (ex_src[j*REG_AW +: REG_AW]),
            .sel   (fwd_sel[j*SELW +: SELW])
        );
    end

    assign stall       = stall_w;
    assign stall_count = stall_count_q;

endmodule
